// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with redirect handling and a one-entry output record.
// Optional FETCH_STALL_CNT_EN adds a stall_cnt output counting request cycles without a response.
module fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [63:0] out_pcplus4,
   output logic [31:0] out_instr
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [63:0] stall_cnt
`endif
);
   typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
   state_t      r_state;
   logic [63:0] r_pc, r_pend, r_out_pc, r_out_pc4;
   logic [31:0] r_out_instr;
   logic        r_out_valid;
   logic [63:0] w_pc4;
   assign w_pc4       = r_pc + 64'd4;
   assign ireq_valid  = r_state != HOLD;
   assign ireq_addr   = r_pc;
   assign out_valid   = r_out_valid;
   assign out_pc      = r_out_pc;
   assign out_pcplus4 = r_out_pc4;
   assign out_instr   = r_out_instr;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= FETCH;
         r_pc        <= RESET_PC;
         r_pend      <= '0;
         r_out_valid <= 1'b0;
         r_out_pc    <= '0;
         r_out_pc4   <= '0;
         r_out_instr <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (redirect_valid) begin
                  if (iresp_data_ok) r_pc <= redirect_pc;
                  else begin
                     r_pend  <= redirect_pc;
                     r_state <= DROP;
                  end
               end else if (iresp_data_ok) begin
                  r_out_valid <= 1'b1;
                  r_out_pc    <= r_pc;
                  r_out_pc4   <= w_pc4;
                  r_out_instr <= iresp_data;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (redirect_valid || out_ready) begin
                  r_out_valid <= 1'b0;
                  r_pc        <= redirect_valid ? redirect_pc : w_pc4;
                  r_state     <= FETCH;
               end
            end
            DROP: begin
               // The stale response must drain before the pending target is issued
               if (redirect_valid) r_pend <= redirect_pc;
               if (iresp_data_ok) begin
                  r_pc    <= redirect_valid ? redirect_pc : r_pend;
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end
`ifdef FETCH_STALL_CNT_EN
   logic [63:0] r_stall_cnt;
   assign stall_cnt = r_stall_cnt;
   always_ff @(posedge clk) begin
      if (reset) r_stall_cnt <= '0;
      else if (ireq_valid && !iresp_data_ok) r_stall_cnt <= r_stall_cnt + 64'd1;
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven fetch transactions with a record scoreboard, plus redirect/reset sequences.
module tb_fetch_stage;
   localparam logic [63:0] RPC = 64'h8000_0000;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok = 1'b0;
   logic [31:0] iresp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc, out_pcplus4;
   logic [31:0] out_instr;
`ifdef FETCH_STALL_CNT_EN
   logic [63:0] stall_cnt;
`endif
   int checks = 0;
   int failures = 0;

   fetch_stage #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_pcplus4(out_pcplus4), .out_instr(out_instr)
`ifdef FETCH_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      int          lat;
      int          hold;
   } vec_t;
   typedef struct {
      logic [63:0] pc;
      logic [63:0] pc4;
      logic [31:0] instr;
   } rec_t;
   vec_t vecs[4];
   rec_t sb[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_rec(input logic [63:0] pc, input logic [31:0] instr);
      rec_t r;
      r.pc = pc;
      r.pc4 = pc + 64'd4;
      r.instr = instr;
      sb.push_back(r);
   endtask

   task automatic pop_rec(input string name);
      rec_t r;
      chk({name, ".out_valid"}, {63'd0, out_valid}, 64'd1);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty got 0 expected 1 entry", name);
      end else begin
         r = sb.pop_front();
         chk({name, ".out_pc"}, out_pc, r.pc);
         chk({name, ".out_pcplus4"}, out_pcplus4, r.pc4);
         chk({name, ".out_instr"}, {32'd0, out_instr}, {32'd0, r.instr});
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One full fetch: wait lat cycles, respond, hold for hold cycles, accept.
   task automatic run_fetch(input string name, input vec_t v);
      logic [63:0] held_pc;
      chk({name, ".ireq_valid"}, {63'd0, ireq_valid}, 64'd1);
      chk({name, ".ireq_addr"}, ireq_addr, v.pc);
      for (int k = 0; k < v.lat; k++) begin
         tick();
         chk({name, ".addr_stable"}, ireq_addr, v.pc);
      end
      iresp_data_ok = 1'b1;
      iresp_data = v.instr;
      push_rec(v.pc, v.instr);
      tick();
      iresp_data_ok = 1'b0;
      pop_rec(name);
      chk({name, ".hold_noreq"}, {63'd0, ireq_valid}, 64'd0);
      held_pc = out_pc;
      for (int k = 0; k < v.hold; k++) begin
         tick();
         chk({name, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
         chk({name, ".hold_pc"}, out_pc, held_pc);
         chk({name, ".hold_instr"}, {32'd0, out_instr}, {32'd0, v.instr});
         chk({name, ".hold_noreq"}, {63'd0, ireq_valid}, 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, ".acc_valid"}, {63'd0, out_valid}, 64'd0);
      chk({name, ".next_addr"}, ireq_addr, v.pc + 64'd4);
   endtask

   initial begin
      vec_t w;
      vecs[0] = '{pc: RPC,               instr: 32'h0000_0013, lat: 0, hold: 0};
      vecs[1] = '{pc: RPC + 64'd4,       instr: 32'h0010_0093, lat: 2, hold: 5};
      vecs[2] = '{pc: RPC + 64'd8,       instr: 32'hdead_beef, lat: 1, hold: 1};
      vecs[3] = '{pc: RPC + 64'd12,      instr: 32'h1234_5678, lat: 3, hold: 0};
      do_reset();
      chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst.out_pc", out_pc, 64'd0);
      chk("rst.out_pcplus4", out_pcplus4, 64'd0);
      chk("rst.out_instr", {32'd0, out_instr}, 64'd0);
      chk("rst.addr", ireq_addr, RPC);
      for (int i = 0; i < 4; i++) run_fetch($sformatf("vec%0d", i), vecs[i]);
      // Redirect with outstanding fetch at 0x80000010; response arrives 3 cycles later
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_1000;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("drop.addr_held", ireq_addr, RPC + 64'd16);
         chk("drop.req", {63'd0, ireq_valid}, 64'd1);
         tick();
      end
      chk("drop.addr_held", ireq_addr, RPC + 64'd16);
      iresp_data_ok = 1'b1;
      iresp_data = 32'hbad0_0001;
      tick();
      iresp_data_ok = 1'b0;
      chk("drop.no_out", {63'd0, out_valid}, 64'd0);
      chk("drop.new_addr", ireq_addr, 64'h8000_1000);
      // Redirect coincident with data_ok
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_2000;
      iresp_data_ok = 1'b1;
      tick();
      redirect_valid = 1'b0;
      iresp_data_ok = 1'b0;
      chk("same.no_out", {63'd0, out_valid}, 64'd0);
      chk("same.addr", ireq_addr, 64'h8000_2000);
      chk("same.req", {63'd0, ireq_valid}, 64'd1);
      // Redirect in HOLD with out_ready drops the record
      iresp_data_ok = 1'b1;
      iresp_data = 32'h0000_0073;
      push_rec(64'h8000_2000, 32'h0000_0073);
      tick();
      iresp_data_ok = 1'b0;
      pop_rec("holdredir");
      redirect_valid = 1'b1;
      redirect_pc = 64'hffff_ffff_ffff_fffc;
      out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      chk("holdredir.dropped", {63'd0, out_valid}, 64'd0);
      chk("holdredir.addr", ireq_addr, 64'hffff_ffff_ffff_fffc);
      // PC+4 wraps modulo 2^64
      w = '{pc: 64'hffff_ffff_ffff_fffc, instr: 32'h0000_006f, lat: 1, hold: 2};
      run_fetch("wrap", w);
      chk("wrap.addr_zero", ireq_addr, 64'd0);
      // Repeated redirects in DROP: last one wins, incl. same cycle as data_ok
      redirect_valid = 1'b1;
      redirect_pc = 64'h100;
      tick();
      redirect_pc = 64'h200;
      tick();
      redirect_pc = 64'h300;
      iresp_data_ok = 1'b1;
      tick();
      redirect_valid = 1'b0;
      iresp_data_ok = 1'b0;
      chk("multi.same_cycle", ireq_addr, 64'h300);
      redirect_valid = 1'b1;
      redirect_pc = 64'h401;
      tick();
      redirect_pc = 64'h502;
      tick();
      redirect_valid = 1'b0;
      chk("multi.held", ireq_addr, 64'h300);
      iresp_data_ok = 1'b1;
      tick();
      iresp_data_ok = 1'b0;
      chk("multi.last_wins", ireq_addr, 64'h502);
      chk("multi.no_out", {63'd0, out_valid}, 64'd0);
      // Reset during DROP overrides data_ok and redirect
      redirect_valid = 1'b1;
      redirect_pc = 64'h600;
      tick();
      reset = 1'b1;
      iresp_data_ok = 1'b1;
      redirect_pc = 64'h700;
      tick();
      reset = 1'b0;
      redirect_valid = 1'b0;
      iresp_data_ok = 1'b0;
      chk("rstdrop.addr", ireq_addr, RPC);
      chk("rstdrop.out_valid", {63'd0, out_valid}, 64'd0);
      chk("rstdrop.req", {63'd0, ireq_valid}, 64'd1);
`ifdef FETCH_STALL_CNT_EN
      do_reset();
      chk("stall.rst", stall_cnt, 64'd0);
      for (int k = 0; k < 4; k++) tick();
      iresp_data_ok = 1'b1;
      iresp_data = 32'h0000_0013;
      push_rec(RPC, 32'h0000_0013);
      tick();
      iresp_data_ok = 1'b0;
      pop_rec("stall");
      chk("stall.cnt4", stall_cnt, 64'd4);
      do_reset();
      chk("stall.cleared", stall_cnt, 64'd0);
`endif
      run_fetch("post_rst", vecs[0]);
      chk("sb.empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
